// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared widths, opcode and state encodings for proc_controller
package proc_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int NREG_DEF   = 8;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_T1   = 2'd1,
    S_T2   = 2'd2,
    S_T3   = 2'd3
  } state_t;

endpackage

// File: rtl/proc_controller_if.sv
// rtl/proc_controller_if.sv - run/instruction handshake and packed register bus
interface proc_controller_if #(
  parameter int DATA_W = proc_pkg::DATA_W_DEF,
  parameter int NREG   = proc_pkg::NREG_DEF
);
  import proc_pkg::*;

  logic                   run;
  logic [DATA_W-1:0]      din;
  logic [NREG*DATA_W-1:0] r_q;
  logic [NREG*DATA_W-1:0] r_d;
  logic                   done;
  logic                   busy;

  modport master (output run, output din, output r_q,
                  input  r_d, input  done, input  busy);

  modport slave  (input  run, input  din, input  r_q,
                  output r_d, output done, output busy);

endinterface

// File: rtl/addsub.sv
// rtl/addsub.sv - modulo-2^W adder/subtractor; carry and borrow are dropped
module addsub #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] result
);

  assign result = sub ? (a - b) : (a + b);

endmodule

// File: rtl/proc_controller.sv
// rtl/proc_controller.sv - four-state instruction sequencer driving an external register block
module proc_controller
  import proc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREG   = NREG_DEF
) (
  input  logic              clk,
  input  logic              rst,
  proc_controller_if.slave  bus
);

  state_t            state_q, state_d;
  logic [8:0]        ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] g_q, g_d;

  logic [2:0]        op;
  int                xi, yi;
  logic [DATA_W-1:0] rx, ry, sum;
  logic              wr_en;
  logic [DATA_W-1:0] wr_val;
  logic              done_int;
  logic [NREG*DATA_W-1:0] r_d_w;

  assign op = ir_q[8:6];
  assign xi = int'(ir_q[5:3]);
  assign yi = int'(ir_q[2:0]);
  assign rx = bus.r_q[xi*DATA_W +: DATA_W];
  assign ry = bus.r_q[yi*DATA_W +: DATA_W];

  addsub #(.W(DATA_W)) u_addsub (
    .a      (a_q),
    .b      (ry),
    .sub    (op == OP_SUB),
    .result (sum)
  );

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    a_d      = a_q;
    g_d      = g_q;
    wr_en    = 1'b0;
    wr_val   = '0;
    done_int = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.run) begin
          ir_d    = bus.din[8:0];
          state_d = S_T1;
        end
      end
      S_T1: begin
        case (op)
          OP_MV: begin
            wr_en    = 1'b1;
            wr_val   = ry;
            done_int = 1'b1;
            state_d  = S_IDLE;
          end
          OP_MVI: begin
            wr_en    = 1'b1;
            wr_val   = bus.din;
            done_int = 1'b1;
            state_d  = S_IDLE;
          end
          OP_ADD, OP_SUB: begin
            a_d     = rx;
            state_d = S_T2;
          end
          default: begin
            done_int = 1'b1;
            state_d  = S_IDLE;
          end
        endcase
      end
      S_T2: begin
        g_d     = sum;
        state_d = S_T3;
      end
      S_T3: begin
        wr_en    = 1'b1;
        wr_val   = g_q;
        done_int = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // rst gates the write so an instruction caught mid-flight never reaches the register block
  always_comb begin
    r_d_w = bus.r_q;
    if (wr_en && !rst) begin
      r_d_w[xi*DATA_W +: DATA_W] = wr_val;
    end
  end

  assign bus.r_d  = r_d_w;
  assign bus.done = done_int && !rst;
  assign bus.busy = (state_q != S_IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      a_q     <= '0;
      g_q     <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      g_q     <= g_d;
    end
  end

endmodule
